unit_rd_scoreboard: RTL and testbench
=====================================

# unit_rd_scoreboard

Sequential, parametrised scoreboard tracking the destination register of every multi-cycle execution unit (div, FP add/mul/div/sqrt, FMA, …) in the rv32imf core. It holds one slot per unit from issue to writeback and raises a RAW stall when a new instruction reads an in-flight rd. On a resolvable WAW hazard it squashes the older writer, so its writeback is suppressed instead of stalling. It sits between decode/issue and the unit writeback arbiter.

## Interface
Parameters:
- NUM_UNITS, 9, number of tracked execution units (slots)
- RD_W, 5, register-address width
- UNIT_IDX_W, $clog2(NUM_UNITS), width of a unit index

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; invalidates every slot
- iss_valid  in  1  instruction issuing this cycle
- iss_unit  in  UNIT_IDX_W  target unit index
- iss_rd  in  RD_W  destination register
- iss_rd_fp  in  1  rd is in the FP file (0 = integer file)
- iss_writes  in  1  instruction writes rd
- iss_rs1, iss_rs2, iss_rs3  in  RD_W  source registers
- iss_rs1_fp, iss_rs2_fp, iss_rs3_fp  in  1  file of each source
- iss_rs3_used  in  1  R4 (fused multiply-add) instruction
- wb_valid  in  NUM_UNITS  unit i delivers its result this cycle
- raw_stall  out  1  issue must hold (combinational)
- unit_busy_stall  out  1  target unit slot occupied and not completing (combinational)
- clear_unit  out  NUM_UNITS  one-hot squash pulse for the older writer (combinational)
- wb_write_en  out  NUM_UNITS  unit i writeback may update the register file
- slot_busy  out  NUM_UNITS  registered slot-valid vector

## Operation
- Slot state per unit: valid, rd, rd_fp, squashed.
- Match(slot, r, fp): valid && !wb_valid[i] && rd == r && rd_fp == fp. Slots completing this cycle are treated as forwarded and never match.
- Integer x0 is never tracked. An issue with rd = x0 integer, or with iss_writes = 0, allocates nothing. FP f0 is tracked normally.
- raw_stall = iss_valid && (any matching slot for rs1 or rs2, or for rs3 when iss_rs3_used). Slots with squashed = 1 are excluded.
- unit_busy_stall = iss_valid && slot[iss_unit].valid && !wb_valid[iss_unit].
- Accept = iss_valid && !raw_stall && !unit_busy_stall && !flush.
- WAW: on accept with a tracked rd, every other non-squashed slot matching (iss_rd, iss_rd_fp) asserts clear_unit[j] this cycle and sets squashed[j] next cycle. A source equal to rd is already covered by raw_stall, so no clear is issued in that case.
- Allocation: on accept with a tracked rd, slot[iss_unit] ← {1, iss_rd, iss_rd_fp, 0} next cycle.
- Release: wb_valid[i] clears slot i next cycle. wb_write_en[i] = wb_valid[i] && slot[i].valid && !slot[i].squashed.
- Same-cycle wb_valid[i] and accept to unit i: allocation wins; the slot holds the new rd.
- wb_valid[i] on an invalid slot: wb_write_en[i] = 0, no state change. This is a protocol error and the bench flags it.
- flush: all slots invalid next cycle. clear_unit is forced to 0 and no allocation happens that cycle.

## Timing
- Reset: all slots invalid, squashed = 0. slot_busy = 0. raw_stall, unit_busy_stall, clear_unit and wb_write_en are all 0.
- Stalls and clear_unit are combinational in the issue cycle. The slot update is visible on slot_busy one cycle later.
- Release to re-issue of a dependent instruction: 0 cycles, because the completing slot is excluded from matching.
- A reset asserted mid-operation drops all slots immediately. Writebacks in flight at that point are not tracked.

## Structure
- Shared package rv32_sb_pkg: slot_t struct {valid, rd, rd_fp, squashed} and the NUM_UNITS / RD_W defaults.
- Sub-module sb_slot: one register slot with its allocate, release, squash and flush logic and its three source comparators. It is instantiated NUM_UNITS times by a generate loop.
- The top level holds the OR-reductions, the stall logic and the one-hot iss_unit decode.

## Test plan
- Reset, then issue div x5 to unit 0 → slot_busy = 0x001. Next instruction with rs1 = x5 → raw_stall = 1. wb_valid[0] in the same cycle → raw_stall = 0.
- fmul f3 on unit 2, then fadd f3 (sources f1, f2) on unit 3 → clear_unit = 0x004. Unit 2 writeback later → wb_write_en[2] = 0. Unit 3 writeback → wb_write_en[3] = 1.
- fmul f3 in flight, then fmadd f3 with rs3 = f3 → raw_stall = 1, clear_unit = 0.
- Integer rd = x0 issued to unit 0 → slot_busy stays 0, and a following rs1 = x0 read does not stall.
- Issue to unit 1 while busy → unit_busy_stall = 1. Same cycle with wb_valid[1] = 1 → accepted, and the slot holds the new rd.
- Two slots busy, then flush → slot_busy = 0 next cycle. Reset asserted mid-division → all outputs 0 asynchronously.

Source files
------------

// File: rtl/rv32_sb_pkg.sv
// Shared types and defaults for the multi-cycle unit destination-register scoreboard.
// Slot records carry the in-flight rd of one execution unit from issue to writeback.
package rv32_sb_pkg;

    localparam int NUM_UNITS_DEF = 9;
    localparam int RD_W_DEF      = 5;
    // rd field sized for the widest supported register address; narrower rd is zero-extended
    localparam int RD_W_MAX      = 6;

    typedef struct packed {
        logic                valid;
        logic [RD_W_MAX-1:0] rd;
        logic                rd_fp;
        logic                squashed;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: {RD_W_MAX{1'b0}}, rd_fp: 1'b0, squashed: 1'b0};

    // Integer x0 is hardwired to zero, so only FP registers or non-zero integer rd are tracked
    function automatic logic rd_is_tracked(input logic writes, input logic rd_fp, input logic rd_nonzero);
        return writes && (rd_fp || rd_nonzero);
    endfunction

endpackage

// File: rtl/sb_slot.sv
// One scoreboard slot: holds the in-flight rd of a single execution unit and
// compares it against the issuing instruction's sources and destination.
module sb_slot
    import rv32_sb_pkg::*;
#(
    parameter int RD_W = RD_W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            alloc,
    input  logic            squash,
    input  logic            wb_valid,
    input  logic [RD_W-1:0] iss_rd,
    input  logic            iss_rd_fp,
    input  logic [RD_W-1:0] iss_rs1,
    input  logic            iss_rs1_fp,
    input  logic [RD_W-1:0] iss_rs2,
    input  logic            iss_rs2_fp,
    input  logic [RD_W-1:0] iss_rs3,
    input  logic            iss_rs3_fp,
    input  logic            iss_rs3_used,
    output logic            busy,
    output logic            src_hit,
    output logic            rd_hit,
    output logic            wb_write_en
);

    slot_t slot_r;
    logic  live_s;
    logic  hit_rs1_s;
    logic  hit_rs2_s;
    logic  hit_rs3_s;
    logic  hit_rd_s;

    // A slot completing this cycle is forwarded, so it never matches
    assign live_s    = slot_r.valid && !wb_valid;
    assign hit_rs1_s = live_s && (slot_r.rd == RD_W_MAX'(iss_rs1)) && (slot_r.rd_fp == iss_rs1_fp);
    assign hit_rs2_s = live_s && (slot_r.rd == RD_W_MAX'(iss_rs2)) && (slot_r.rd_fp == iss_rs2_fp);
    assign hit_rs3_s = live_s && (slot_r.rd == RD_W_MAX'(iss_rs3)) && (slot_r.rd_fp == iss_rs3_fp);
    assign hit_rd_s  = live_s && (slot_r.rd == RD_W_MAX'(iss_rd))  && (slot_r.rd_fp == iss_rd_fp);

    assign src_hit     = !slot_r.squashed && (hit_rs1_s || hit_rs2_s || (iss_rs3_used && hit_rs3_s));
    assign rd_hit      = !slot_r.squashed && hit_rd_s;
    assign wb_write_en = wb_valid && slot_r.valid && !slot_r.squashed;
    assign busy        = slot_r.valid;

    // Slot state: flush empties, a new allocation beats a same-cycle release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_r <= SLOT_EMPTY;
        end else if (flush) begin
            slot_r <= SLOT_EMPTY;
        end else if (alloc) begin
            slot_r <= '{valid: 1'b1, rd: RD_W_MAX'(iss_rd), rd_fp: iss_rd_fp, squashed: 1'b0};
        end else if (squash) begin
            slot_r.squashed <= 1'b1;
        end else if (wb_valid) begin
            slot_r <= SLOT_EMPTY;
        end else begin
            slot_r <= slot_r;
        end
    end

endmodule

// File: rtl/unit_rd_scoreboard.sv
// Scoreboard of in-flight destination registers for the multi-cycle execution units:
// raises RAW / unit-busy stalls at issue and squashes older writers on WAW.
module unit_rd_scoreboard
    import rv32_sb_pkg::*;
#(
    parameter int NUM_UNITS  = NUM_UNITS_DEF,
    parameter int RD_W       = RD_W_DEF,
    parameter int UNIT_IDX_W = $clog2(NUM_UNITS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  iss_valid,
    input  logic [UNIT_IDX_W-1:0] iss_unit,
    input  logic [RD_W-1:0]       iss_rd,
    input  logic                  iss_rd_fp,
    input  logic                  iss_writes,
    input  logic [RD_W-1:0]       iss_rs1,
    input  logic [RD_W-1:0]       iss_rs2,
    input  logic [RD_W-1:0]       iss_rs3,
    input  logic                  iss_rs1_fp,
    input  logic                  iss_rs2_fp,
    input  logic                  iss_rs3_fp,
    input  logic                  iss_rs3_used,
    input  logic [NUM_UNITS-1:0]  wb_valid,
    output logic                  raw_stall,
    output logic                  unit_busy_stall,
    output logic [NUM_UNITS-1:0]  clear_unit,
    output logic [NUM_UNITS-1:0]  wb_write_en,
    output logic [NUM_UNITS-1:0]  slot_busy
);

    logic [NUM_UNITS-1:0] unit_sel_s;
    logic [NUM_UNITS-1:0] src_hit_s;
    logic [NUM_UNITS-1:0] rd_hit_s;
    logic [NUM_UNITS-1:0] alloc_s;
    logic                 tracked_s;
    logic                 accept_s;
    logic                 grant_s;

    // One-hot decode of the target unit; out-of-range indices select nothing
    always_comb begin
        unit_sel_s = {NUM_UNITS{1'b0}};
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_sel_s[i] = (iss_unit == UNIT_IDX_W'(i));
        end
    end

    assign tracked_s       = rd_is_tracked(iss_writes, iss_rd_fp, |iss_rd);
    assign raw_stall       = iss_valid && (|src_hit_s);
    assign unit_busy_stall = iss_valid && (|(unit_sel_s & slot_busy & ~wb_valid));
    assign accept_s        = iss_valid && !raw_stall && !unit_busy_stall && !flush;
    assign grant_s         = accept_s && tracked_s;

    // The target slot is either idle or completing, so it never appears in rd_hit_s
    assign clear_unit = {NUM_UNITS{grant_s}} & rd_hit_s & ~unit_sel_s;
    assign alloc_s    = {NUM_UNITS{grant_s}} & unit_sel_s;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slot
        sb_slot #(
            .RD_W (RD_W)
        ) u_slot (
            .clk          (clk),
            .reset_n      (reset_n),
            .flush        (flush),
            .alloc        (alloc_s[i]),
            .squash       (clear_unit[i]),
            .wb_valid     (wb_valid[i]),
            .iss_rd       (iss_rd),
            .iss_rd_fp    (iss_rd_fp),
            .iss_rs1      (iss_rs1),
            .iss_rs1_fp   (iss_rs1_fp),
            .iss_rs2      (iss_rs2),
            .iss_rs2_fp   (iss_rs2_fp),
            .iss_rs3      (iss_rs3),
            .iss_rs3_fp   (iss_rs3_fp),
            .iss_rs3_used (iss_rs3_used),
            .busy         (slot_busy[i]),
            .src_hit      (src_hit_s[i]),
            .rd_hit       (rd_hit_s[i]),
            .wb_write_en  (wb_write_en[i])
        );
    end

endmodule

// File: tb/tb_unit_rd_scoreboard.sv
// Directed bench for unit_rd_scoreboard: a register-level model of the in-flight
// destinations predicts every output each cycle, plus hand-computed pins.
module tb_unit_rd_scoreboard;

    localparam int NU = 9;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          iss_valid;
    logic [3:0]    iss_unit;
    logic [4:0]    iss_rd;
    logic          iss_rd_fp;
    logic          iss_writes;
    logic [4:0]    iss_rs1;
    logic [4:0]    iss_rs2;
    logic [4:0]    iss_rs3;
    logic          iss_rs1_fp;
    logic          iss_rs2_fp;
    logic          iss_rs3_fp;
    logic          iss_rs3_used;
    logic [NU-1:0] wb_valid;
    logic          raw_stall;
    logic          unit_busy_stall;
    logic [NU-1:0] clear_unit;
    logic [NU-1:0] wb_write_en;
    logic [NU-1:0] slot_busy;

    unit_rd_scoreboard dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .iss_valid       (iss_valid),
        .iss_unit        (iss_unit),
        .iss_rd          (iss_rd),
        .iss_rd_fp       (iss_rd_fp),
        .iss_writes      (iss_writes),
        .iss_rs1         (iss_rs1),
        .iss_rs2         (iss_rs2),
        .iss_rs3         (iss_rs3),
        .iss_rs1_fp      (iss_rs1_fp),
        .iss_rs2_fp      (iss_rs2_fp),
        .iss_rs3_fp      (iss_rs3_fp),
        .iss_rs3_used    (iss_rs3_used),
        .wb_valid        (wb_valid),
        .raw_stall       (raw_stall),
        .unit_busy_stall (unit_busy_stall),
        .clear_unit      (clear_unit),
        .wb_write_en     (wb_write_en),
        .slot_busy       (slot_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model: which register each unit will still write, and whether that write is dead
    bit m_valid [NU];
    int m_rd    [NU];
    bit m_fp    [NU];
    bit m_sq    [NU];

    logic          last_raw;
    logic          last_ubs;
    logic [NU-1:0] last_clear;
    logic [NU-1:0] last_wbe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit pending_read(input int r, input bit fp);
        for (int i = 0; i < NU; i++) begin
            if (m_valid[i] && !m_sq[i] && !wb_valid[i] && m_rd[i] == r && m_fp[i] == fp) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NU; i++) begin
            m_valid[i] = 1'b0;
            m_rd[i]    = 0;
            m_fp[i]    = 1'b0;
            m_sq[i]    = 1'b0;
        end
    endtask

    // Compare all outputs against the model, then advance model and DUT by one clock
    task automatic step(input string tag);
        bit            e_raw, e_ubs, acc, trk;
        logic [NU-1:0] e_clear, e_wbe, e_busy;
        int            u;
        #1;
        u     = int'(iss_unit);
        e_raw = iss_valid && (pending_read(int'(iss_rs1), iss_rs1_fp) ||
                              pending_read(int'(iss_rs2), iss_rs2_fp) ||
                              (iss_rs3_used && pending_read(int'(iss_rs3), iss_rs3_fp)));
        e_ubs = iss_valid && u < NU && m_valid[u] && !wb_valid[u];
        acc   = iss_valid && !e_raw && !e_ubs && !flush;
        trk   = iss_writes && (iss_rd_fp || iss_rd != 5'd0);
        for (int j = 0; j < NU; j++) begin
            e_clear[j] = acc && trk && j != u && m_valid[j] && !m_sq[j] && !wb_valid[j] &&
                         m_rd[j] == int'(iss_rd) && m_fp[j] == iss_rd_fp;
            e_wbe[j]   = wb_valid[j] && m_valid[j] && !m_sq[j];
            e_busy[j]  = m_valid[j];
            if (wb_valid[j] && !m_valid[j]) $display("note: protocol error, writeback from idle unit %0d (%s)", j, tag);
        end
        chk({tag, ".raw_stall"}, 32'(raw_stall), 32'(e_raw));
        chk({tag, ".unit_busy_stall"}, 32'(unit_busy_stall), 32'(e_ubs));
        chk({tag, ".clear_unit"}, 32'(clear_unit), 32'(e_clear));
        chk({tag, ".wb_write_en"}, 32'(wb_write_en), 32'(e_wbe));
        chk({tag, ".slot_busy"}, 32'(slot_busy), 32'(e_busy));
        last_raw   = raw_stall;
        last_ubs   = unit_busy_stall;
        last_clear = clear_unit;
        last_wbe   = wb_write_en;
        @(posedge clk);
        for (int i = 0; i < NU; i++) begin
            if (flush) begin
                m_valid[i] = 1'b0;
                m_sq[i]    = 1'b0;
            end else if (acc && trk && i == u) begin
                m_valid[i] = 1'b1;
                m_rd[i]    = int'(iss_rd);
                m_fp[i]    = iss_rd_fp;
                m_sq[i]    = 1'b0;
            end else if (e_clear[i]) begin
                m_sq[i] = 1'b1;
            end else if (wb_valid[i]) begin
                m_valid[i] = 1'b0;
                m_sq[i]    = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        flush        = 1'b0;
        iss_valid    = 1'b0;
        iss_unit     = 4'd0;
        iss_rd       = 5'd0;
        iss_rd_fp    = 1'b0;
        iss_writes   = 1'b0;
        iss_rs1      = 5'd0;
        iss_rs2      = 5'd0;
        iss_rs3      = 5'd0;
        iss_rs1_fp   = 1'b0;
        iss_rs2_fp   = 1'b0;
        iss_rs3_fp   = 1'b0;
        iss_rs3_used = 1'b0;
        wb_valid     = {NU{1'b0}};
    endtask

    // Issue a writing instruction whose sources live in the same register file as rd
    task automatic iss(input int unit, input int rd, input bit fp, input int rs1, input int rs2,
                       input int rs3, input bit rs3u);
        iss_valid    = 1'b1;
        iss_unit     = 4'(unit);
        iss_rd       = 5'(rd);
        iss_rd_fp    = fp;
        iss_writes   = 1'b1;
        iss_rs1      = 5'(rs1);
        iss_rs2      = 5'(rs2);
        iss_rs3      = 5'(rs3);
        iss_rs1_fp   = fp;
        iss_rs2_fp   = fp;
        iss_rs3_fp   = fp;
        iss_rs3_used = rs3u;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        step("reset");
        chk("reset_busy_pin", 32'(slot_busy), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // div x5 on unit 0, then a reader of x5, then the same reader while unit 0 completes
        idle(); iss(0, 5, 1'b0, 1, 2, 0, 1'b0); step("div_x5");
        chk("div_alloc_pin", 32'(slot_busy), 32'h001);
        idle(); iss(1, 6, 1'b0, 5, 2, 0, 1'b0); step("raw_x5");
        chk("raw_x5_pin", 32'(last_raw), 32'h1);
        idle(); iss(1, 6, 1'b0, 5, 2, 0, 1'b0); wb_valid = 9'h001; step("raw_fwd");
        chk("raw_fwd_pin", 32'(last_raw), 32'h0);
        chk("raw_fwd_wbe_pin", 32'(last_wbe), 32'h001);
        chk("raw_fwd_busy_pin", 32'(slot_busy), 32'h002);
        idle(); wb_valid = 9'h002; step("drain_u1");

        // WAW on f3: fadd squashes the older fmul
        idle(); iss(2, 3, 1'b1, 1, 2, 0, 1'b0); step("fmul_f3");
        idle(); iss(3, 3, 1'b1, 1, 2, 0, 1'b0); step("fadd_f3");
        chk("waw_clear_pin", 32'(last_clear), 32'h004);
        chk("waw_busy_pin", 32'(slot_busy), 32'h00C);
        idle(); wb_valid = 9'h004; step("wb_squashed");
        chk("wb_squashed_pin", 32'(last_wbe), 32'h000);
        idle(); wb_valid = 9'h008; step("wb_live");
        chk("wb_live_pin", 32'(last_wbe), 32'h008);

        // fmadd f3 reading f3 via rs3 stalls instead of squashing
        idle(); iss(2, 3, 1'b1, 1, 2, 0, 1'b0); step("fmul_f3_again");
        idle(); iss(4, 3, 1'b1, 1, 2, 3, 1'b1); step("fmadd_rs3");
        chk("fmadd_raw_pin", 32'(last_raw), 32'h1);
        chk("fmadd_clear_pin", 32'(last_clear), 32'h000);
        idle(); wb_valid = 9'h004; step("drain_u2");

        // x0 destination is not tracked, and reading x0 never stalls
        idle(); iss(0, 0, 1'b0, 1, 2, 0, 1'b0); step("rd_x0");
        chk("rd_x0_pin", 32'(slot_busy), 32'h000);
        idle(); iss(1, 7, 1'b0, 0, 0, 0, 1'b0); step("rs_x0");
        chk("rs_x0_pin", 32'(last_raw), 32'h0);

        // Unit 1 busy, then same-cycle release and re-allocation
        idle(); iss(1, 8, 1'b0, 1, 2, 0, 1'b0); step("unit_busy");
        chk("unit_busy_pin", 32'(last_ubs), 32'h1);
        idle(); iss(1, 8, 1'b0, 1, 2, 0, 1'b0); wb_valid = 9'h002; step("busy_release");
        chk("busy_release_pin", 32'(last_ubs), 32'h0);
        chk("busy_release_wbe_pin", 32'(last_wbe), 32'h002);
        idle(); iss(5, 9, 1'b0, 8, 2, 0, 1'b0); step("holds_x8");
        chk("holds_x8_pin", 32'(last_raw), 32'h1);
        idle(); iss(5, 9, 1'b0, 7, 2, 0, 1'b0); step("dropped_x7");
        chk("dropped_x7_pin", 32'(slot_busy), 32'h022);

        // Flush with an issue in the same cycle
        idle(); iss(0, 10, 1'b0, 1, 2, 0, 1'b0); step("third_busy");
        idle(); iss(6, 11, 1'b0, 1, 2, 0, 1'b0); flush = 1'b1; step("flush");
        chk("flush_pin", 32'(slot_busy), 32'h000);

        // Integer WAW, FP/integer separation, and writeback of a squashed plus live unit
        idle(); iss(0, 20, 1'b0, 1, 2, 0, 1'b0); step("int_x20_a");
        idle(); iss(6, 20, 1'b0, 1, 2, 0, 1'b0); step("int_x20_b");
        chk("int_waw_pin", 32'(last_clear), 32'h001);
        idle(); iss(7, 21, 1'b1, 20, 2, 0, 1'b0); step("fp_reads_f20");
        chk("fp_sep_pin", 32'(last_raw), 32'h0);
        idle(); iss(8, 22, 1'b0, 20, 1, 0, 1'b0); step("int_reads_x20");
        idle(); wb_valid = 9'h0C1; step("wb_mixed");
        chk("wb_mixed_pin", 32'(last_wbe), 32'h0C0);

        // Writeback from an idle unit changes nothing
        idle(); wb_valid = 9'h010; step("wb_idle");
        chk("wb_idle_pin", 32'(last_wbe), 32'h000);

        // Reset mid-division drops everything asynchronously
        idle(); iss(0, 12, 1'b0, 1, 2, 0, 1'b0); step("div_x12");
        idle(); iss(0, 13, 1'b0, 12, 2, 0, 1'b0);
        reset_n = 1'b0;
        #1;
        model_clear();
        chk("rst_raw_pin", 32'(raw_stall), 32'h0);
        chk("rst_ubs_pin", 32'(unit_busy_stall), 32'h0);
        chk("rst_clear_pin", 32'(clear_unit), 32'h000);
        chk("rst_wbe_pin", 32'(wb_write_en), 32'h000);
        chk("rst_busy_pin", 32'(slot_busy), 32'h000);
        @(negedge clk);
        reset_n = 1'b1;
        idle(); step("post_reset");
        idle(); iss(0, 13, 1'b0, 12, 2, 0, 1'b0); step("post_reset_issue");
        chk("post_reset_issue_pin", 32'(slot_busy), 32'h001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
